// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: widths, the prefetch queue entry and the
// memory address width shared with the unified 1Kx16 memory.
package fetch_pkg;

  localparam int ADDR_W        = 16;
  localparam int INST_W        = 16;
  localparam int MEM_ADDR_BITS = 10;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Sequential next PC. The increment wraps 16'hFFFF -> 16'h0000.
  function automatic logic [ADDR_W-1:0] nextPc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch_entry_t used as the prefetch queue.
// Flush has priority over push/pop; flush and reset are both synchronous.
// DEPTH must be a power of two (2..8) so the pointers wrap naturally.
// The head is read from storage (or a held copy when empty), so there is
// never a combinational path from pushData to head.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t pushData,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t         storage [DEPTH];
  fetch_entry_t         holdEntry;
  logic [PTR_W-1:0]     rdPtr;
  logic [PTR_W-1:0]     wrPtr;
  logic [CNT_W-1:0]     count;
  logic                 doPush;
  logic                 doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop && !empty;
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign doPush = push && (!full || doPop);

  // When empty, present the last head seen so decode sees stable (don't-care) values.
  assign head = empty ? holdEntry : storage[rdPtr];

  // Entry storage: written on an accepted push; no reset needed since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && doPush) begin
      storage[wrPtr] <= pushData;
    end
  end

  // Pointer and occupancy tracking; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Remember the current head so the outputs hold once the queue drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      holdEntry <= '0;
    end else if (!empty) begin
      holdEntry <= storage[rdPtr];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the memory instruction port,
// captures fetched words into a prefetch queue and hands {pc, inst} to decode.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
//
// Decode handshake: inst_valid means the head entry is present and stays
// asserted until it is accepted; an entry is consumed on any rising edge where
// inst_valid && inst_ready, except that a redirect in the same cycle flushes
// the queue and that pop is discarded with everything else.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] iAddr,
  input  logic [INST_W-1:0] iDataOut,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count
`endif
);

  logic [ADDR_W-1:0] pc;
  logic              qFull;
  logic              qEmpty;
  logic              popReq;
  logic              capture;
  fetch_entry_t      pushEntry;
  fetch_entry_t      headEntry;

  assign iAddr      = pc;
  assign inst_valid = !qEmpty;
  assign inst       = headEntry.inst;
  assign inst_pc    = headEntry.addr;

  assign popReq  = inst_valid && inst_ready;
  // Fetch only when enabled, not redirecting, and there is (or will be) room.
  assign capture = fetch_en && !redirect && (!qFull || popReq);

  assign pushEntry.addr = pc;
  assign pushEntry.inst = iDataOut;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (capture),
    .pop      (popReq),
    .flush    (redirect),
    .pushData (pushEntry),
    .head     (headEntry),
    .full     (qFull),
    .empty    (qEmpty)
  );

  // Program counter: reset, redirect target, or advance on each capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (capture) begin
      pc <= nextPc(pc);
    end
  end

`ifdef FETCH_PERF_EN
  logic stallCycle;

  // A stall is a cycle that wanted to fetch but the queue was full and not draining.
  assign stallCycle = fetch_en && !redirect && qFull && !popReq;

  // Saturating push and stall counters; redirect does not clear them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (capture && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
      if (stallCycle && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a queue-based reference model.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] iAddr;
  logic [15:0] iDataOut;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [15:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  // Memory model: mem[i] = 16'hA000 + i, addressed by iAddr[9:0].
  logic [15:0] mem [1024];
  assign iDataOut = mem[iAddr[9:0]];

  // Reference model state: queue of {pc, inst}, the PC, and counters.
  logic [31:0] exp_q[$];
  logic [15:0] mPc;
  int          mFetch;
  int          mStall;

  fetch_unit #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .iAddr       (iAddr),
    .iDataOut    (iDataOut),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the reference model across one rising edge using current inputs.
  task automatic model_edge();
    logic [15:0] word;
    bit          pop;
    bit          full;
    if (!rst_n) begin
      exp_q.delete();
      mPc    = RESET_PC;
      mFetch = 0;
      mStall = 0;
    end else if (redirect) begin
      exp_q.delete();
      mPc = redirect_pc;
    end else begin
      pop  = (exp_q.size() > 0) && inst_ready;
      full = (exp_q.size() == DEPTH);
      if (fetch_en && full && !pop && mStall < 65535) mStall++;
      if (pop) void'(exp_q.pop_front());
      if (fetch_en && (!full || pop)) begin
        word = 16'hA000 + 16'(mPc % 1024);
        exp_q.push_back({mPc, word});
        mPc = mPc + 16'd1;
        if (mFetch < 65535) mFetch++;
      end
    end
  endtask

  // One clock: rising edge (model follows), then settle to the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    step();
    step();
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    checks++;
    if (inst !== 16'h0000) begin errors++; $display("FAIL reset_inst got %h want 0000", inst); end
    checks++;
    if (inst_pc !== 16'h0000) begin errors++; $display("FAIL reset_inst_pc got %h want 0000", inst_pc); end
    checks++;
    if (iAddr !== RESET_PC) begin errors++; $display("FAIL reset_iaddr got %h want %h", iAddr, RESET_PC); end
  endtask

  task automatic test_stream();
    rst_n = 1'b1; fetch_en = 1'b1; inst_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 16'(k - 1) || inst !== 16'hA000 + 16'(k - 1)) begin
        errors++;
        $display("FAIL stream_%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 k, inst_valid, inst_pc, inst, 16'(k - 1), 16'hA000 + 16'(k - 1));
      end
    end
  endtask

  task automatic test_backpressure();
    int j;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    inst_ready = 1'b0;
    for (int k = 0; k < 6; k++) step();
    checks++;
    if (iAddr !== 16'h0002) begin errors++; $display("FAIL bp_iaddr got %h want 0002", iAddr); end
    checks++;
    if (inst_valid !== 1'b1 || inst !== 16'hA000) begin
      errors++; $display("FAIL bp_head got v=%b inst=%h want v=1 inst=a000", inst_valid, inst);
    end
    inst_ready = 1'b1;
    j = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst !== 16'hA000 + 16'(j)) begin
        errors++; $display("FAIL bp_drain_%0d got v=%b inst=%h want v=1 inst=%h", j, inst_valid, inst, 16'hA000 + 16'(j));
      end
      j++;
      step();
    end
  endtask

  task automatic test_redirect();
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (exp_q.size() != DEPTH || inst_valid !== 1'b1) begin
      errors++; $display("FAIL redir_setup got v=%b want v=1 with full queue", inst_valid);
    end
    redirect = 1'b1; redirect_pc = 16'h0100; inst_ready = 1'($urandom_range(0, 1));
    step();
    redirect = 1'b0; inst_ready = 1'b1;
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", inst_valid); end
    checks++;
    if (iAddr !== 16'h0100) begin errors++; $display("FAIL redir_iaddr got %h want 0100", iAddr); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 16'h0100 + 16'(k) || inst !== 16'hA100 + 16'(k)) begin
        errors++;
        $display("FAIL redir_next_%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 k, inst_valid, inst_pc, inst, 16'h0100 + 16'(k), 16'hA100 + 16'(k));
      end
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 16'hFFFF; inst_ready = 1'b1;
    step();
    redirect = 1'b0; inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || iAddr !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_redir got v=%b iaddr=%h want v=0 iaddr=ffff", inst_valid, iAddr);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 16'hFFFF || inst !== 16'hA3FF) begin
      errors++; $display("FAIL wrap_first got v=%b pc=%h inst=%h want v=1 pc=ffff inst=a3ff", inst_valid, inst_pc, inst);
    end
    step();
    inst_ready = 1'b1;
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 16'h0000 || inst !== 16'hA000) begin
      errors++; $display("FAIL wrap_second got v=%b pc=%h inst=%h want v=1 pc=0000 inst=a000", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; inst_ready = 1'b1;
    checks++;
    if (inst_valid !== 1'b0 || iAddr !== RESET_PC) begin
      errors++; $display("FAIL rstmid_state got v=%b iaddr=%h want v=0 iaddr=%h", inst_valid, iAddr, RESET_PC);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 16'(k) || inst !== 16'hA000 + 16'(k)) begin
        errors++; $display("FAIL rstmid_stream_%0d got v=%b pc=%h inst=%h want pc=%h", k, inst_valid, inst_pc, inst, 16'(k));
      end
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0; fetch_en = 1'b1; inst_ready = 1'b0; step();
    rst_n = 1'b1;
    step(); step();                       // two pushes fill the queue
    inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();   // eight pop+push cycles -> 10 pushes
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();   // three full, back-pressured cycles
    checks++;
    if (fetch_count !== 16'd10) begin errors++; $display("FAIL perf_fetch got %0d want 10", fetch_count); end
    checks++;
    if (stall_count !== 16'd3) begin errors++; $display("FAIL perf_stall got %0d want 3", stall_count); end
  endtask
`endif

  // Randomized traffic compared every cycle against the reference model.
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      fetch_en    = ($urandom_range(0, 9) < 8);
      inst_ready  = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom_range(0, 65535));
      rst_n       = ($urandom_range(0, 99) != 0);
      step();
      checks++;
      if (inst_valid !== (exp_q.size() > 0)) begin
        errors++; $display("FAIL rand_valid_%0d got %b want %b", k, inst_valid, exp_q.size() > 0);
      end else if (exp_q.size() > 0) begin
        checks++;
        if ({inst_pc, inst} !== exp_q[0]) begin
          errors++; $display("FAIL rand_head_%0d got %h want %h", k, {inst_pc, inst}, exp_q[0]);
        end
      end
      checks++;
      if (iAddr !== mPc) begin errors++; $display("FAIL rand_iaddr_%0d got %h want %h", k, iAddr, mPc); end
`ifdef FETCH_PERF_EN
      checks++;
      if (fetch_count !== 16'(mFetch) || stall_count !== 16'(mStall)) begin
        errors++; $display("FAIL rand_perf_%0d got f=%0d s=%0d want f=%0d s=%0d", k, fetch_count, stall_count, mFetch, mStall);
      end
`endif
    end
    redirect = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hA000 + 16'(i);
    mPc = RESET_PC; mFetch = 0; mStall = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the unified 1K×16 memory's instruction port.
- Owns the program counter and drives the memory's 16-bit instruction address.
- Captures the combinational instruction word into a small prefetch queue and hands {pc, instruction} to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) from execute and flushes stale prefetches.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- QUEUE_DEPTH, 2, prefetch queue entries; power of two, 2..8.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- fetch_en  in  1  1 = allowed to issue new fetches; 0 = hold PC and let the queue drain.
- redirect  in  1  1-cycle pulse: flush queue, load PC from redirect_pc.
- redirect_pc  in  16  redirect target address.
- iAddr  out  16  instruction address to memory; equals pc combinationally.
- iDataOut  in  16  instruction word from memory; valid in the same cycle as iAddr.
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  decode accepts the head this cycle.
- inst  out  16  head instruction word.
- inst_pc  out  16  address the head instruction was fetched from.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc <= RESET_PC.
  - Queue emptied.
  - Outputs: inst_valid=0, inst=0, inst_pc=0, iAddr=RESET_PC.
  - Reset mid-operation discards all queued entries; no partial state survives.
- Capture condition: fetch_en=1 AND redirect=0 AND (queue not full OR pop this cycle).
  - On capture, push {pc, iDataOut} and set pc <= pc+1.
  - The increment wraps 16'hFFFF -> 16'h0000. No aliasing check is done here; memory uses only iAddr[9:0].
- Pop condition: inst_valid AND inst_ready.
  - Simultaneous push and pop when the queue is full is legal; occupancy stays the same.
- Redirect has the highest priority after reset.
  - The queue is flushed, pc <= redirect_pc, and nothing is pushed that cycle.
  - Any pop in the same cycle is discarded with the flush; decode must not rely on it being counted.
  - Next cycle: inst_valid=0 and iAddr=redirect_pc. The target instruction is valid 2 cycles after the redirect edge, provided fetch_en=1.
- Latency: 1 cycle from capture to inst_valid. After reset release, the first instruction is valid at the 2nd rising edge.
- Queue full and no pop: pc holds and iAddr is stable.
- Queue empty: inst_valid=0, and inst/inst_pc hold their last values (don't-care for decode).
- fetch_en=0: no push and pc holds. Existing entries still drain. A redirect still loads pc and flushes.
- Head outputs are registered or read from queue storage; there is no combinational path from iDataOut to inst.
- inst_valid, once asserted, stays asserted until popped, flushed, or reset.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined:
  - Adds output ports fetch_count[15:0] and stall_count[15:0], both reset to 0.
  - fetch_count increments on every push.
  - stall_count increments on every cycle with fetch_en=1, redirect=0, queue full and no pop.
  - Both counters saturate at 16'hFFFF and are not cleared by redirect.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - ADDR_W=16, INST_W=16.
  - typedef fetch_entry_t {addr[15:0], inst[15:0]}.
  - The MEM_ADDR_BITS=10 constant, shared with memory.
- One sub-module, fetch_queue: a synchronous FIFO of fetch_entry_t with push, pop, flush (highest priority), full, empty and head output. Flush and reset are both synchronous.
- The PC register and capture/redirect control live in fetch_unit.

Test Plan (memory model preloaded mem[i]=16'hA000+i):
- Reset, release, inst_ready=1 held -> stream inst_pc 0,1,2,… with inst 16'hA000,16'hA001,…; one instruction per cycle after 1-cycle latency.
- inst_ready=0 for 6 cycles -> queue fills to 2 (inst 16'hA000 held), iAddr stops at 2; release -> 16'hA000,16'hA001,16'hA002 in order with no gaps or duplicates.
- Redirect to 16'h0100 while 2 entries are queued -> inst_valid low next cycle; next delivered is inst_pc=16'h0100, inst=16'hA100; no stale entries appear.
- Redirect to 16'hFFFF, run 2 fetches -> inst_pc 16'hFFFF then 16'h0000 (wrap); inst = mem[16'h3FF] then mem[0].
- rst_n low for 1 cycle mid-stream with a full queue -> next cycle inst_valid=0 and iAddr=RESET_PC; streaming restarts at inst_pc 0.
- (FETCH_PERF_EN) 10 pushes, then 3 back-pressured full cycles -> fetch_count=10, stall_count=3.
